xfer_ctrl: RTL

- Control unit for the memory-to-memory transfer path.
- Scans memory A sequentially by pulsing IncA to the A address counter.
- Compares each word with its predecessor.
- For every strictly increasing pair, writes the difference into memory B, then pulses IncB to the 2-bit B address counter.
- Sits upstream of both address counters and drives memory B's write port.

---
 rtl/xfer_ctrl_if.sv | 28 ++
 rtl/xfer_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/xfer_ctrl_if.sv
// Bundle of the transfer-controller signals: scan request, memory A read side,
// counter increment strobes, memory B write port and status flags.
interface xfer_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          Start;
    logic [AW-1:0] AddrA;
    logic [DW-1:0] DOutA;
    logic          IncA;
    logic          IncB;
    logic          WEB;
    logic [DW-1:0] DInB;
    logic [2:0]    WrCount;
    logic          Busy;
    logic          Done;
    logic          Overflow;

    modport master (
        input  Start, AddrA, DOutA,
        output IncA, IncB, WEB, DInB, WrCount, Busy, Done, Overflow
    );

    modport slave (
        output Start, AddrA, DOutA,
        input  IncA, IncB, WEB, DInB, WrCount, Busy, Done, Overflow
    );
endinterface

// File: rtl/xfer_ctrl.sv
// Scans memory A, and for every strictly increasing neighbour pair writes the
// difference into the 4-entry memory B; one scan per Reset.
module xfer_ctrl #(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int NA = 8,
    parameter int NB = 4
) (
    input logic         clock,
    input logic         Reset,
    xfer_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CMP   = 3'd2,
        S_WRITE = 3'd3,
        S_INCB  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_A = AW'(NA - 1);
    localparam logic [2:0]    NB_W   = 3'(NB);

    state_t        state_q, state_d;
    logic [DW-1:0] prev_q, prev_d;
    logic [DW-1:0] dinb_q, dinb_d;
    logic [2:0]    wr_count_q, wr_count_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          last_flag_q, last_flag_d;
    logic          inc_a_s;
    logic          qual_s;
    logic          is_last_s;

    // State and datapath registers; Reset aborts a scan at once.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            prev_q      <= {DW{1'b0}};
            dinb_q      <= {DW{1'b0}};
            wr_count_q  <= 3'd0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            last_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            dinb_q      <= dinb_d;
            wr_count_q  <= wr_count_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            last_flag_q <= last_flag_d;
        end
    end

    // Next-state, datapath updates and the Mealy IncA strobe.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        dinb_d      = dinb_q;
        wr_count_d  = wr_count_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        last_flag_d = last_flag_q;
        inc_a_s     = 1'b0;
        qual_s      = (bus.DOutA > prev_q);
        is_last_s   = (bus.AddrA == LAST_A);

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                prev_d  = bus.DOutA;
                inc_a_s = 1'b1;
                state_d = S_CMP;
            end
            S_CMP: begin
                prev_d      = bus.DOutA;
                last_flag_d = is_last_s;
                inc_a_s     = !is_last_s;
                if (qual_s && (wr_count_q < NB_W)) begin
                    // Strict compare guarantees the difference is positive.
                    dinb_d  = bus.DOutA - prev_q;
                    state_d = S_WRITE;
                end else begin
                    if (qual_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (is_last_s) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CMP;
                    end
                end
            end
            S_WRITE: begin
                wr_count_d = wr_count_q + 3'd1;
                state_d    = S_INCB;
            end
            S_INCB: begin
                // B address moves only after the write edge has passed.
                if (last_flag_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_CMP;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.IncA     = inc_a_s;
    assign bus.IncB     = (state_q == S_INCB);
    assign bus.WEB      = (state_q == S_WRITE);
    assign bus.Busy     = (state_q == S_LOAD) || (state_q == S_CMP) ||
                          (state_q == S_WRITE) || (state_q == S_INCB);
    assign bus.DInB     = dinb_q;
    assign bus.WrCount  = wr_count_q;
    assign bus.Done     = done_q;
    assign bus.Overflow = overflow_q;

endmodule
